// File: rtl/regfile_pkg.sv
// Shared widths and state encoding for the regfile arbiter.
package regfile_pkg;

  localparam int REG_W    = 8;
  localparam int RADDR_W  = 2;
  localparam int NUM_REGS = 4;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles the debug port was refused.
module starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic async_rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Clear wins over increment; the count holds once it reaches LIMIT.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_limit = (cnt == W'(LIMIT));

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the 4x8 regfile ports between the core (priority) and a debug
// valid/ready port, and holds the regfile in sync reset for one cycle
// after async reset.
//
// state | meaning
// INIT  | one cycle after reset: regfile sync reset, core stalled
// IDLE  | core passes through; debug granted on a free port (or forced)
// RESP  | debug response held until consumed; core passes through
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic               core_rd_en_A,
  input  logic               core_rd_en_B,
  input  logic [RADDR_W-1:0] core_addr_A,
  input  logic [RADDR_W-1:0] core_addr_B,
  input  logic               core_wr_en,
  input  logic [RADDR_W-1:0] core_wr_addr,
  input  logic [REG_W-1:0]   core_wr_data,
  output logic               core_stall,
  input  logic               dbg_req_valid,
  output logic               dbg_req_ready,
  input  logic               dbg_req_write,
  input  logic [RADDR_W-1:0] dbg_req_addr,
  input  logic [REG_W-1:0]   dbg_req_wdata,
  output logic               dbg_rsp_valid,
  input  logic               dbg_rsp_ready,
  output logic [REG_W-1:0]   dbg_rsp_data,
  output logic               rf_sync_rst,
  output logic               rf_read_en_A,
  output logic               rf_read_en_B,
  output logic               rf_write_en,
  output logic [RADDR_W-1:0] rf_addr_read_A,
  output logic [RADDR_W-1:0] rf_addr_read_B,
  output logic [RADDR_W-1:0] rf_addr_write,
  output logic [REG_W-1:0]   rf_data_in,
  input  logic [REG_W-1:0]   rf_data_out_A,
  input  logic [REG_W-1:0]   rf_data_out_B
);

  arb_state_t state;
  logic       forced;
  logic       grant_a;
  logic       grant_b;
  logic       grant_w;
  logic       cnt_clr;
  logic       cnt_inc;

  // A refused debug request counts toward the forced core stall.
  assign cnt_inc = (state == IDLE) && dbg_req_valid && !dbg_req_ready;
  assign cnt_clr = !cnt_inc;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_counter (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .at_limit   (forced)
  );

  // Port steering: core by default, debug takes whichever port the core left free.
  always_comb begin
    rf_sync_rst    = 1'b0;
    core_stall     = 1'b0;
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    grant_w        = 1'b0;
    rf_read_en_A   = core_rd_en_A;
    rf_read_en_B   = core_rd_en_B;
    rf_write_en    = core_wr_en;
    rf_addr_read_A = core_addr_A;
    rf_addr_read_B = core_addr_B;
    rf_addr_write  = core_wr_addr;
    rf_data_in     = core_wr_data;

    case (state)
      INIT: begin
        rf_sync_rst  = 1'b1;
        core_stall   = 1'b1;
        rf_read_en_A = 1'b0;
        rf_read_en_B = 1'b0;
        rf_write_en  = 1'b0;
      end
      IDLE: begin
        if (forced) begin
          core_stall   = 1'b1;
          rf_read_en_A = 1'b0;
          rf_read_en_B = 1'b0;
          rf_write_en  = 1'b0;
          if (dbg_req_valid) begin
            grant_w = dbg_req_write;
            grant_b = !dbg_req_write;
          end
        end else if (dbg_req_valid) begin
          if (dbg_req_write) begin
            grant_w = !core_wr_en;
          end else if (!core_rd_en_B) begin
            grant_b = 1'b1;
          end else if (!core_rd_en_A) begin
            grant_a = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (grant_a) begin
      rf_read_en_A   = 1'b1;
      rf_addr_read_A = dbg_req_addr;
    end
    if (grant_b) begin
      rf_read_en_B   = 1'b1;
      rf_addr_read_B = dbg_req_addr;
    end
    if (grant_w) begin
      rf_write_en   = 1'b1;
      rf_addr_write = dbg_req_addr;
      rf_data_in    = dbg_req_wdata;
    end
  end

  assign dbg_req_ready = grant_a | grant_b | grant_w;

  // Sequencer: INIT -> IDLE, capture response on grant, release it on handshake.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state         <= INIT;
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_data  <= '0;
    end else begin
      case (state)
        INIT: state <= IDLE;
        IDLE: begin
          if (dbg_req_ready) begin
            dbg_rsp_valid <= 1'b1;
            if (grant_w)      dbg_rsp_data <= '0;
            else if (grant_a) dbg_rsp_data <= rf_data_out_A;
            else              dbg_rsp_data <= rf_data_out_B;
            state <= RESP;
          end
        end
        RESP: begin
          if (dbg_rsp_ready) begin
            dbg_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
